// File: rtl/vga_pkg.sv
// Shared timing constants, zoom encodings and helpers for the VGA stream controller.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam logic [1:0] ZOOM_1X = 2'd0;
  localparam logic [1:0] ZOOM_2X = 2'd1;
  localparam logic [1:0] ZOOM_4X = 2'd2;

  typedef struct packed {
    logic active;
    logic hsAct;
    logic vsAct;
  } timingBits_t;

  function automatic int timingTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // The unused encoding 3 falls back to 1x.
  function automatic logic [1:0] zoomShift(input logic [1:0] mode);
    case (mode)
      ZOOM_2X: return 2'd1;
      ZOOM_4X: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters with active, sync and frame-start decode.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] hCnt,
  output logic [CNT_W-1:0] vCnt,
  output timingBits_t      timing,
  output logic             frameStart
);

  localparam int H_TOTAL = timingTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timingTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // started holds the counters at 0,0 for the first edge after reset so that
  // position 0,0 is presented for a full cycle before the scan advances.
  logic started;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hCnt    <= '0;
      vCnt    <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (started) begin
        if (hCnt == H_LAST) begin
          hCnt <= '0;
          vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
        end else begin
          hCnt <= hCnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    timing.active = started && (hCnt < H_VIS) && (vCnt < V_VIS);
    timing.hsAct  = started && (hCnt >= HS_START) && (hCnt < HS_END);
    timing.vsAct  = started && (vCnt >= VS_START) && (vCnt < VS_END);
  end

  assign frameStart = started && (hCnt == '0) && (vCnt == '0);

endmodule

// File: rtl/vga_stream_controller.sv
// VGA timing and pixel-fetch controller: zoomed fetch coordinates at S1, DAC outputs at S2.
module vga_stream_controller
  import vga_pkg::*;
#(
  parameter int RGB_SIZE = 8,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RGB_SIZE-1:0] i_red,
  input  logic [RGB_SIZE-1:0] i_green,
  input  logic [RGB_SIZE-1:0] i_blue,
  input  logic [1:0]          i_zoom_mode,
  output logic                o_request,
  output logic [CNT_W-1:0]    o_pix_x,
  output logic [CNT_W-1:0]    o_pix_y,
  output logic                o_frame_start,
  output logic [RGB_SIZE-1:0] o_vga_r,
  output logic [RGB_SIZE-1:0] o_vga_g,
  output logic [RGB_SIZE-1:0] o_vga_b,
  output logic                o_vga_hsync,
  output logic                o_vga_vsync,
  output logic                o_vga_sync_n,
  output logic                o_vga_blank_n
);

  logic [CNT_W-1:0] hCnt;
  logic [CNT_W-1:0] vCnt;
  timingBits_t      s0Timing;
  timingBits_t      s1Timing;
  timingBits_t      srcTiming;
  logic             s0FrameStart;
  logic [1:0]       zoomQ;
  logic [1:0]       shift;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CNT_W    (CNT_W)
  ) u_syncCounter (
    .clk        (clk),
    .reset      (reset),
    .hCnt       (hCnt),
    .vCnt       (vCnt),
    .timing     (s0Timing),
    .frameStart (s0FrameStart)
  );

  // Zoom only changes at the frame boundary so a frame is never scaled two ways.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zoomQ <= ZOOM_1X;
    end else if (s0FrameStart) begin
      zoomQ <= i_zoom_mode;
    end
  end

  assign shift = zoomShift(zoomQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_request     <= 1'b0;
      o_frame_start <= 1'b0;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      s1Timing      <= '0;
    end else begin
      o_request     <= s0Timing.active;
      o_frame_start <= s0FrameStart;
      s1Timing      <= s0Timing;
      if (s0Timing.active) begin
        o_pix_x <= hCnt >> shift;
        o_pix_y <= vCnt >> shift;
      end
    end
  end

  // Matches the one-cycle frame-buffer latency so timing bits meet their pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srcTiming <= '0;
    end else begin
      srcTiming <= s1Timing;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_vga_r       <= '0;
      o_vga_g       <= '0;
      o_vga_b       <= '0;
      o_vga_hsync   <= ~SYNC_POL;
      o_vga_vsync   <= ~SYNC_POL;
      o_vga_sync_n  <= 1'b1;
      o_vga_blank_n <= 1'b0;
    end else begin
      o_vga_r       <= srcTiming.active ? i_red   : '0;
      o_vga_g       <= srcTiming.active ? i_green : '0;
      o_vga_b       <= srcTiming.active ? i_blue  : '0;
      o_vga_hsync   <= srcTiming.hsAct ? SYNC_POL : ~SYNC_POL;
      o_vga_vsync   <= srcTiming.vsAct ? SYNC_POL : ~SYNC_POL;
      o_vga_sync_n  <= ~(srcTiming.hsAct | srcTiming.vsAct);
      o_vga_blank_n <= srcTiming.active;
    end
  end

endmodule

// File: tb/tb_vga_stream_controller.sv
// Directed bench for vga_stream_controller on a shrunken 15x8 timing.
module tb_vga_stream_controller;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = 15, VT = 8, FT = 120, CW = 11;

  if ((HA + HF + HS + HB - 1) >= (1 << CW) || (VA + VF + VS + VB - 1) >= (1 << CW)) begin : gCntCheck
    $fatal(1, "CNT_W too narrow for the chosen timing");
  end

  logic          clk;
  logic          rst;
  logic [7:0]    iRed, iGreen, iBlue;
  logic [1:0]    iZoom;
  logic          oRequest, oFrameStart;
  logic [CW-1:0] oPixX, oPixY;
  logic [7:0]    oR, oG, oB;
  logic          oHs, oVs, oSyncN, oBlankN;

  vga_stream_controller #(
    .RGB_SIZE (8),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .i_red         (iRed),
    .i_green       (iGreen),
    .i_blue        (iBlue),
    .i_zoom_mode   (iZoom),
    .o_request     (oRequest),
    .o_pix_x       (oPixX),
    .o_pix_y       (oPixY),
    .o_frame_start (oFrameStart),
    .o_vga_r       (oR),
    .o_vga_g       (oG),
    .o_vga_b       (oB),
    .o_vga_hsync   (oHs),
    .o_vga_vsync   (oVs),
    .o_vga_sync_n  (oSyncN),
    .o_vga_blank_n (oBlankN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad, k, srcMode;
  logic [CW-1:0] mX, mY;
  logic [1:0]    mZoom;
  logic [CW-1:0] xH [1024];

  // Frame-buffer source with one cycle of latency.
  always @(posedge clk) begin
    if (srcMode == 1) begin
      iRed   <= oPixX[7:0];
      iGreen <= oPixY[7:0];
    end else begin
      iRed   <= 8'h55;
      iGreen <= 8'h55;
    end
    iBlue <= 8'h55;
  end

  function automatic bit actAt(int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction
  function automatic bit hsAt(int p);
    return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
  endfunction
  function automatic bit vsAt(int p);
    return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
  endfunction

  // k counts edges since reset release; S1 shows position k-2, S2 shows k-4.
  task automatic tick();
    logic [1:0] zb;
    int p, h, v, sh;
    zb = iZoom;
    @(posedge clk);
    k++;
    if (k >= 2) begin
      p = (k - 2) % FT;
      h = p % HT;
      v = p / HT;
      if (p == 0) mZoom = zb;
      sh = (mZoom == 2'd1) ? 1 : (mZoom == 2'd2) ? 2 : 0;
      if (actAt(p)) begin
        mX = CW'(h >> sh);
        mY = CW'(v >> sh);
      end
      xH[k % 1024] = mX;
    end
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic releaseReset();
    rst = 1'b0;
    k = 0;
    mX = '0;
    mY = '0;
    mZoom = 2'd0;
  endtask

  task automatic test_reset();
    applyReset();
    total++; if (oRequest !== 1'b0) begin bad++; $display("FAIL rst_request got=%0b exp=0", oRequest); end
    total++; if (oFrameStart !== 1'b0) begin bad++; $display("FAIL rst_frame_start got=%0b exp=0", oFrameStart); end
    total++; if ({oR, oG, oB} !== 24'h0) begin bad++; $display("FAIL rst_rgb got=%h exp=0", {oR, oG, oB}); end
    total++; if (oHs !== 1'b1 || oVs !== 1'b1) begin bad++; $display("FAIL rst_syncs got=%0b%0b exp=11", oHs, oVs); end
    total++; if (oSyncN !== 1'b1) begin bad++; $display("FAIL rst_sync_n got=%0b exp=1", oSyncN); end
    total++; if (oBlankN !== 1'b0) begin bad++; $display("FAIL rst_blank_n got=%0b exp=0", oBlankN); end
    total++; if (oPixX !== '0 || oPixY !== '0) begin bad++; $display("FAIL rst_pix got=%0d,%0d exp=0,0", oPixX, oPixY); end
    releaseReset();
    tick();
    total++; if (oFrameStart !== 1'b0) begin bad++; $display("FAIL edge1_frame_start got=%0b exp=0", oFrameStart); end
    total++; if (oRequest !== 1'b0) begin bad++; $display("FAIL edge1_request got=%0b exp=0", oRequest); end
    tick();
    total++; if (oFrameStart !== 1'b1) begin bad++; $display("FAIL edge2_frame_start got=%0b exp=1", oFrameStart); end
    total++; if (oRequest !== 1'b1) begin bad++; $display("FAIL edge2_request got=%0b exp=1", oRequest); end
    tick();
    total++; if (oFrameStart !== 1'b0) begin bad++; $display("FAIL edge3_frame_start got=%0b exp=0", oFrameStart); end
    total++; if (oPixX !== CW'(1)) begin bad++; $display("FAIL edge3_pix_x got=%0d exp=1", oPixX); end
  endtask

  task automatic test_free_run();
    int p1, p2, lastFs, reqCount;
    srcMode = 0;
    iZoom = 2'd0;
    applyReset();
    releaseReset();
    lastFs = 0;
    reqCount = 0;
    repeat (2 * FT + 6) begin
      tick();
      if (k >= 2) begin
        p1 = (k - 2) % FT;
        total++; if (oRequest !== actAt(p1)) begin bad++; $display("FAIL run_request k=%0d got=%0b exp=%0b", k, oRequest, actAt(p1)); end
        total++; if (oFrameStart !== (p1 == 0)) begin bad++; $display("FAIL run_frame_start k=%0d got=%0b exp=%0b", k, oFrameStart, p1 == 0); end
        total++; if (oPixX !== mX || oPixY !== mY) begin bad++; $display("FAIL run_pix k=%0d got=%0d,%0d exp=%0d,%0d", k, oPixX, oPixY, mX, mY); end
        if (oFrameStart === 1'b1) begin
          if (lastFs != 0) begin
            total++; if (k - lastFs != FT) begin bad++; $display("FAIL run_frame_period got=%0d exp=%0d", k - lastFs, FT); end
          end
          lastFs = k;
        end
        if (k < 2 + FT && oRequest === 1'b1) reqCount++;
      end
      if (k >= 4) begin
        p2 = (k - 4) % FT;
        total++; if (oHs !== !hsAt(p2)) begin bad++; $display("FAIL run_hsync k=%0d got=%0b exp=%0b", k, oHs, !hsAt(p2)); end
        total++; if (oVs !== !vsAt(p2)) begin bad++; $display("FAIL run_vsync k=%0d got=%0b exp=%0b", k, oVs, !vsAt(p2)); end
        total++; if (oSyncN !== !(hsAt(p2) || vsAt(p2))) begin bad++; $display("FAIL run_sync_n k=%0d got=%0b", k, oSyncN); end
        total++; if (oBlankN !== actAt(p2)) begin bad++; $display("FAIL run_blank_n k=%0d got=%0b exp=%0b", k, oBlankN, actAt(p2)); end
        total++; if ({oR, oG, oB} !== (actAt(p2) ? 24'h555555 : 24'h0)) begin bad++; $display("FAIL run_rgb k=%0d got=%h", k, {oR, oG, oB}); end
      end
    end
    total++; if (reqCount != HA * VA) begin bad++; $display("FAIL run_request_count got=%0d exp=%0d", reqCount, HA * VA); end
    total++; if (lastFs == 0) begin bad++; $display("FAIL run_frame_start_seen got=none exp=pulse"); end
  endtask

  task automatic test_echo();
    int p2;
    logic [7:0] expR, expG;
    srcMode = 1;
    iZoom = 2'd0;
    applyReset();
    releaseReset();
    repeat (FT + 6) begin
      tick();
      if (k >= 4) begin
        p2 = (k - 4) % FT;
        expR = actAt(p2) ? 8'(p2 % HT) : 8'h0;
        expG = actAt(p2) ? 8'(p2 / HT) : 8'h0;
        total++; if (oR !== expR) begin bad++; $display("FAIL echo_r k=%0d got=%0d exp=%0d", k, oR, expR); end
        total++; if (oG !== expG) begin bad++; $display("FAIL echo_g k=%0d got=%0d exp=%0d", k, oG, expG); end
        total++; if (oBlankN !== actAt(p2)) begin bad++; $display("FAIL echo_blank_n k=%0d got=%0b", k, oBlankN); end
      end
    end
  endtask

  task automatic test_zoom();
    int zs [4];
    int p1, f, h, v;
    zs = '{0, 1, 2, 0};
    srcMode = 0;
    iZoom = 2'd0;
    applyReset();
    releaseReset();
    repeat (4 * FT + 2) begin
      tick();
      if (k == 60) iZoom = 2'd1;
      if (k == 60 + FT) iZoom = 2'd2;
      if (k == 60 + 2 * FT) iZoom = 2'd3;
      if (k >= 2) begin
        p1 = (k - 2) % FT;
        f = (k - 2) / FT;
        h = p1 % HT;
        v = p1 / HT;
        if (f < 4) begin
          if (actAt(p1)) begin
            total++; if (oPixX !== CW'(h >> zs[f]) || oPixY !== CW'(v >> zs[f])) begin bad++; $display("FAIL zoom_pix f=%0d h=%0d v=%0d got=%0d,%0d exp=%0d,%0d", f, h, v, oPixX, oPixY, h >> zs[f], v >> zs[f]); end
          end else begin
            total++; if (oPixX !== xH[k % 1024]) begin bad++; $display("FAIL zoom_hold k=%0d got=%0d exp=%0d", k, oPixX, xH[k % 1024]); end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    srcMode = 1;
    iZoom = 2'd0;
    applyReset();
    releaseReset();
    while (k < 36) tick();
    rst = 1'b1;
    #1;
    total++; if (oRequest !== 1'b0 || oPixX !== '0 || oPixY !== '0) begin bad++; $display("FAIL mid_async_fetch got=%0b,%0d,%0d exp=0,0,0", oRequest, oPixX, oPixY); end
    total++; if ({oR, oG, oB} !== 24'h0 || oBlankN !== 1'b0) begin bad++; $display("FAIL mid_async_pix got=%h,%0b exp=0,0", {oR, oG, oB}, oBlankN); end
    @(negedge clk);
    total++; if ({oR, oG, oB} !== 24'h0) begin bad++; $display("FAIL mid_rgb got=%h exp=0", {oR, oG, oB}); end
    total++; if (oHs !== 1'b1 || oVs !== 1'b1 || oSyncN !== 1'b1) begin bad++; $display("FAIL mid_syncs got=%0b%0b%0b exp=111", oHs, oVs, oSyncN); end
    total++; if (oBlankN !== 1'b0 || oRequest !== 1'b0) begin bad++; $display("FAIL mid_blank_req got=%0b,%0b exp=0,0", oBlankN, oRequest); end
    @(negedge clk);
    releaseReset();
    tick();
    total++; if (oFrameStart !== 1'b0) begin bad++; $display("FAIL mid_edge1_frame_start got=%0b exp=0", oFrameStart); end
    tick();
    total++; if (oFrameStart !== 1'b1) begin bad++; $display("FAIL mid_edge2_frame_start got=%0b exp=1", oFrameStart); end
    repeat (20) begin
      tick();
      total++; if (oRequest !== actAt((k - 2) % FT) || oPixX !== xH[k % 1024]) begin bad++; $display("FAIL mid_restart k=%0d got=%0b,%0d exp=%0b,%0d", k, oRequest, oPixX, actAt((k - 2) % FT), xH[k % 1024]); end
      if (k >= 4) begin
        total++; if (oR !== (actAt(k - 4) ? 8'((k - 4) % HT) : 8'h0)) begin bad++; $display("FAIL mid_restart_r k=%0d got=%0d", k, oR); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iZoom = 2'd0;
    srcMode = 0;
    total = 0;
    bad = 0;
    k = 0;
    mX = '0;
    mY = '0;
    mZoom = 2'd0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_echo();
    test_zoom();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
